// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder for the mini_soc system_bus slave 0 slot.
// Word-organised storage, byte/half/word writes, optional wait states, two-cycle ERROR response.
module ahb_sram_slave #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned OFFSET_W    = 16,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [31:0] hwdata,
    input  logic        hreadyin,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic [1:0]  hresp
);

    localparam int unsigned AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] LIMIT = 32'(DEPTH_WORDS) * 32'd4;

    typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;

    state_t          state, state_nx;
    logic [3:0]      cnt, cnt_nx;
    logic            pend_valid, pend_valid_nx;
    logic            pend_write;
    logic [AW-1:0]   pend_idx;
    logic [3:0]      pend_be;
    logic [31:0]     rd_buf;
    logic [31:0]     rd_fwd;
    logic [31:0]     mem [DEPTH_WORDS];

    logic [31:0]     off32;
    logic [AW-1:0]   idx_addr;
    logic [3:0]      be_addr;
    logic            legal, ready, accept, complete, wr_now;
    logic            unused_bits;

    assign unused_bits = ^{hburst, htrans[0], haddr};

    assign off32    = 32'(haddr[OFFSET_W-1:0]);
    assign idx_addr = off32[AW+1:2];

    always_comb begin
        legal   = 1'b1;
        be_addr = '0;
        case (hsize)
            3'd0: be_addr = 4'b0001 << off32[1:0];
            3'd1: begin
                be_addr = off32[1] ? 4'b1100 : 4'b0011;
                if (off32[0]) legal = 1'b0;
            end
            3'd2: begin
                be_addr = '1;
                if (off32[1:0] != 2'b00) legal = 1'b0;
            end
            default: legal = 1'b0;
        endcase
        if (off32 >= LIMIT) legal = 1'b0;
    end

    assign ready     = (state != ERR1) && !((state == WAIT) && (cnt != 4'd0));
    assign hreadyout = ready;
    assign hresp     = ((state == ERR1) || (state == ERR2)) ? 2'b01 : 2'b00;
    assign accept    = hsel & hreadyin & htrans[1] & ready;
    assign complete  = pend_valid & ready;
    assign wr_now    = complete & pend_write;
    assign hrdata    = (complete && !pend_write) ? rd_buf : '0;

    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        pend_valid_nx = pend_valid;
        case (state)
            IDLE, ERR2: begin
                state_nx      = IDLE;
                pend_valid_nx = 1'b0;
            end
            WAIT: begin
                if (cnt != 4'd0) begin
                    cnt_nx = cnt - 4'd1;
                end else begin
                    state_nx      = IDLE;
                    pend_valid_nx = 1'b0;
                end
            end
            ERR1: state_nx = ERR2;
            default: state_nx = IDLE;
        endcase
        if (accept) begin
            if (legal) begin
                pend_valid_nx = 1'b1;
                if (WAIT_STATES > 0) begin
                    state_nx = WAIT;
                    cnt_nx   = 4'(WAIT_STATES);
                end else begin
                    state_nx = IDLE;
                end
            end else begin
                pend_valid_nx = 1'b0;
                state_nx      = ERR1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            pend_valid <= 1'b0;
            pend_write <= 1'b0;
            pend_idx   <= '0;
            pend_be    <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            pend_valid <= pend_valid_nx;
            if (accept && legal) begin
                pend_write <= hwrite;
                pend_idx   <= idx_addr;
                pend_be    <= be_addr;
            end
        end
    end

    // Read is sampled on the accept edge, so a write retiring on that same edge is merged in here.
    always_comb begin
        rd_fwd = mem[idx_addr];
        if (wr_now && (pend_idx == idx_addr)) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (pend_be[i]) rd_fwd[8*i +: 8] = hwdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_now) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (pend_be[i]) mem[pend_idx][8*i +: 8] <= hwdata[8*i +: 8];
            end
        end
        if (accept && legal && !hwrite) rd_buf <= rd_fwd;
    end

endmodule
